yuv444_to_422_packer: RTL and testbench
=======================================

Name: yuv444_to_422_packer

Overview:
- Sits directly downstream of the YUV offset stage and receives unsigned 4:4:4 Y/U/V, one pixel per dvi.
- Emits a 4:2:2 stream with one 2*PIXEL_WIDTH word per pixel.
  - Even pixel of a pair carries {Y, Cb}.
  - Odd pixel carries {Y, Cr}.
- Chroma is shared across the pixel pair.
- Non-pixel dtype words (row/frame markers) pass through in stream order.

Parameters:
PIXEL_WIDTH, 8, bit width of each Y/U/V component

Ports:
clk  input  1  clock
resetb  input  1  asynchronous active-low reset
enable  input  1  pack enable; sampled only on `DTYPE_FRAME_START words
dvi  input  1  input word valid
dtypei  input  `DTYPE_WIDTH  input word type
yi  input  PIXEL_WIDTH  luma, unsigned
ui  input  PIXEL_WIDTH  Cb, unsigned (offset-binary)
vi  input  PIXEL_WIDTH  Cr, unsigned (offset-binary)
meta_datai  input  16  sideband travelling with the word
dvo  output  1  output word valid
dtypeo  output  `DTYPE_WIDTH  output word type
datao  output  2*PIXEL_WIDTH  [2W-1:W]=Y, [W-1:0]=chroma
meta_datao  output  16  sideband of the emitted word

Behaviour:
- Reset (async, resetb=0): dvo=0, dtypeo=0, datao=0, meta_datao=0.
  - Internal state cleared: hold slot empty, phase=EVEN, en_lat=0.
- Pixel words are dtypei==`DTYPE_PIXEL. All other dtypes are markers.
- Single hold slot S. Every dvi word is captured into S, or shifts through it.
- S emission rules (at most one output per cycle):
  - S holds odd pixel or marker: emitted the next cycle unconditionally.
  - S holds even pixel: waits in S until the next dvi arrives (gaps of dvi=0 allowed).
    - Next word is a pixel: output {Y0, chroma(U0,U1)}.
    - Next word is a marker: output {Y0, U0} (unpaired, odd-length row).
  - Odd pixel output: {Y1, chroma(Vprev,V1)}. Vprev is the V of its even partner, saved when the even pixel was captured.
- Latency:
  - Odd pixels and markers: 2 cycles from dvi to dvo.
  - Even pixels: 1 cycle after their partner/marker arrives.
  - dtypeo and meta_datao always belong to the emitted word.
- Phase:
  - Toggles on every accepted pixel.
  - Forced to EVEN by any `DTYPE_HEND or `DTYPE_FRAME_START marker. Each row therefore starts on an even pixel.
- enable:
  - Latched into en_lat when a `DTYPE_FRAME_START word is accepted; never changes mid-frame.
  - en_lat=0 (bypass): every word, pixel or marker, is emitted 1 cycle after capture in S, no pairing, datao={Y,U}.
- Chroma width: PIXEL_WIDTH; no saturation needed (average of two unsigned values fits).
- Markers never reorder relative to pixels.
- Reset mid-row: held pixel discarded; no output emitted for it.

Optional Feature:
- Macro: YUV422_CHROMA_AVG_EN.
- Defined: chroma(a,b) = (a+b+1)>>1, computed with a PIXEL_WIDTH+1 bit sum (round half up).
- Undefined: chroma(a,b)=a (decimation, even-pixel U/V used).
  - In this build the even-pixel wait is still kept so output order and timing are identical.

Test Plan:
- Reset check: assert resetb=0 mid-stream → all outputs 0 asynchronously; next row after release starts EVEN.
- Pair, back-to-back, AVG_EN defined: frame start, enable=1, then pixels (Y,U,V)=(10,100,200),(20,103,201) → datao {10,102} then {20,201}.
  - Same stimulus without AVG_EN → {10,100},{20,200}.
- Gapped pair: even pixel, 5 idle cycles, odd pixel → no dvo during gap; even word 1 cycle after odd arrives, odd word next cycle.
- Odd-length row: 3 pixels then `DTYPE_HEND → third pixel output {Y2,U2} unaveraged, then HEND marker.
  - Next row's first pixel carries Cb.
- Bypass: frame start with enable=0, pixels (5,7,9),(6,8,10) → {5,7},{6,8}, each 1 cycle after capture.
  - Toggling enable mid-frame has no effect until the next frame start.
- Marker ordering: HEND and FRAME_START interleaved with full-rate pixels → dtypeo/meta_datao sequence equals the input sequence; dvo never exceeds one word per cycle.

Source files
------------

// File: rtl/yuv444_to_422_packer.sv
// 4:4:4 to 4:2:2 packer: pairs pixels so even words carry {Y,Cb} and odd
// words carry {Y,Cr}; markers pass through in order.
// Optional macro YUV422_CHROMA_AVG_EN: average chroma of the pixel pair
// (round half up) instead of keeping the even pixel's chroma.
// Ports: clk, resetb (async, active low), enable (sampled on frame start),
//   dvi/dtypei/yi/ui/vi/meta_datai in, dvo/dtypeo/datao/meta_datao out.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'd1
`endif
`ifndef DTYPE_HEND
`define DTYPE_HEND 4'd2
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'd3
`endif

module yuv444_to_422_packer #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     enable,
  input  logic                     dvi,
  input  logic [`DTYPE_WIDTH-1:0]  dtypei,
  input  logic [PIXEL_WIDTH-1:0]   yi,
  input  logic [PIXEL_WIDTH-1:0]   ui,
  input  logic [PIXEL_WIDTH-1:0]   vi,
  input  logic [15:0]              meta_datai,
  output logic                     dvo,
  output logic [`DTYPE_WIDTH-1:0]  dtypeo,
  output logic [2*PIXEL_WIDTH-1:0] datao,
  output logic [15:0]              meta_datao
);

  localparam int W = PIXEL_WIDTH;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } phase_t;

  phase_t phase;
  logic   en_lat;

  // hold slot
  logic                    s_vld;
  logic                    s_wait;
  logic                    s_odd;
  logic [`DTYPE_WIDTH-1:0] s_dtype;
  logic [W-1:0]            s_y;
  logic [W-1:0]            s_u;
  logic [W-1:0]            s_v;
  logic [15:0]             s_meta;
  logic [W-1:0]            vprev;

  logic         in_pix;
  logic         in_row_start;
  logic         emit;
  logic [W-1:0] out_c;

  function automatic logic [W-1:0] chroma(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
`ifdef YUV422_CHROMA_AVG_EN
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + (W+1)'(1);
    return sum[W:1];
`else
    // b only matters in the averaging build
    return a | (b & '0);
`endif
  endfunction

  always_comb begin
    in_pix       = (dtypei == `DTYPE_PIXEL);
    in_row_start = (dtypei == `DTYPE_HEND) ||
                   (dtypei == `DTYPE_FRAME_START);
    // a waiting even pixel leaves only when the next word shows up
    emit         = s_vld && (!s_wait || dvi);
    unique case (1'b1)
      s_wait && in_pix: out_c = chroma(s_u, ui);
      s_odd:            out_c = chroma(vprev, s_v);
      default:          out_c = s_u;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      dvo        <= 1'b0;
      dtypeo     <= '0;
      datao      <= '0;
      meta_datao <= '0;
      phase      <= EVEN;
      en_lat     <= 1'b0;
      s_vld      <= 1'b0;
      s_wait     <= 1'b0;
      s_odd      <= 1'b0;
      s_dtype    <= '0;
      s_y        <= '0;
      s_u        <= '0;
      s_v        <= '0;
      s_meta     <= '0;
      vprev      <= '0;
    end else begin
      dvo <= emit;
      if (emit) begin
        dtypeo     <= s_dtype;
        datao      <= {s_y, out_c};
        meta_datao <= s_meta;
      end
      if (dvi) begin
        s_vld   <= 1'b1;
        s_dtype <= dtypei;
        s_y     <= yi;
        s_u     <= ui;
        s_v     <= vi;
        s_meta  <= meta_datai;
        s_wait  <= in_pix && en_lat && (phase == EVEN);
        s_odd   <= in_pix && en_lat && (phase == ODD);
        if (in_pix) begin
          phase <= (phase == EVEN) ? ODD : EVEN;
          if (phase == EVEN) vprev <= vi;
        end else if (in_row_start) begin
          phase <= EVEN;
        end
        if (dtypei == `DTYPE_FRAME_START) en_lat <= enable;
      end else if (emit) begin
        s_vld  <= 1'b0;
        s_wait <= 1'b0;
        s_odd  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_yuv444_to_422_packer.sv
// Bench for yuv444_to_422_packer: vector table plus reset/gap sequences,
// checked through an expected-word queue with emit-cycle tracking.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'd1
`endif
`ifndef DTYPE_HEND
`define DTYPE_HEND 4'd2
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'd3
`endif

module tb_yuv444_to_422_packer;

  localparam logic [3:0] P  = `DTYPE_PIXEL;
  localparam logic [3:0] HE = `DTYPE_HEND;
  localparam logic [3:0] FS = `DTYPE_FRAME_START;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        enable = 1'b0;
  logic        dvi = 1'b0;
  logic [3:0]  dtypei = '0;
  logic [7:0]  yi = '0;
  logic [7:0]  ui = '0;
  logic [7:0]  vi = '0;
  logic [15:0] meta_datai = '0;
  logic        dvo;
  logic [3:0]  dtypeo;
  logic [15:0] datao;
  logic [15:0] meta_datao;

  yuv444_to_422_packer #(.PIXEL_WIDTH(8)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .dvi(dvi),
    .dtypei(dtypei), .yi(yi), .ui(ui), .vi(vi),
    .meta_datai(meta_datai), .dvo(dvo), .dtypeo(dtypeo),
    .datao(datao), .meta_datao(meta_datao)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0]  dtype;
    logic [15:0] data;
    logic [15:0] meta;
    int          at;
  } exp_t;

  typedef struct {
    logic [3:0]  dtype;
    logic        en;
    logic [7:0]  y;
    logic [7:0]  u;
    logic [7:0]  v;
    logic [15:0] meta;
    logic [15:0] e_avg;
    logic [15:0] e_dec;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[$];

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endfunction

  function automatic vec_t mk(logic [3:0] dt, logic en,
                              logic [7:0] y, logic [7:0] u,
                              logic [7:0] v, logic [15:0] meta,
                              logic [15:0] ea, logic [15:0] ed);
    vec_t t;
    t.dtype = dt; t.en = en; t.y = y; t.u = u; t.v = v;
    t.meta = meta; t.e_avg = ea; t.e_dec = ed;
    return t;
  endfunction

  function automatic logic [15:0] sel(logic [15:0] ea, logic [15:0] ed);
`ifdef YUV422_CHROMA_AVG_EN
    return ea | (ed & '0);
`else
    return ed | (ea & '0);
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (resetb && dvo) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_word: got data %0h meta %0h, want none",
                 datao, meta_datao);
      end else begin
        e = sbq.pop_front();
        chk("dtypeo", 32'(dtypeo), 32'(e.dtype));
        chk("datao", 32'(datao), 32'(e.data));
        chk("meta_datao", 32'(meta_datao), 32'(e.meta));
        chk("emit_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  // lat: edges from the word's own sampling edge to its emitting edge
  task automatic send(input logic [3:0] dt, input logic en,
                      input logic [7:0] y, input logic [7:0] u,
                      input logic [7:0] v, input logic [15:0] meta,
                      input logic [15:0] data, input int lat,
                      input bit expect_out);
    exp_t e;
    dvi = 1'b1; dtypei = dt; enable = en;
    yi = y; ui = u; vi = v; meta_datai = meta;
    if (expect_out) begin
      e.dtype = dt; e.data = data; e.meta = meta; e.at = cyc + 1 + lat;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    dvi = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_dvo"}, 32'(dvo), 32'd0);
    chk({tag, "_dtypeo"}, 32'(dtypeo), 32'd0);
    chk({tag, "_datao"}, 32'(datao), 32'd0);
    chk({tag, "_meta"}, 32'(meta_datao), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk) resetb = 1'b1;
    @(posedge clk); #1;

    // pair
    tbl.push_back(mk(FS, 1, 8'h11, 8'h22, 0, 16'h100, 16'h1122, 16'h1122));
    tbl.push_back(mk(P, 1, 10, 100, 200, 16'h101, 16'h0A66, 16'h0A64));
    tbl.push_back(mk(P, 1, 20, 103, 201, 16'h102, 16'h14C9, 16'h14C8));
    // odd-length row
    tbl.push_back(mk(P, 1, 1, 50, 60, 16'h103, 16'h0133, 16'h0132));
    tbl.push_back(mk(P, 1, 2, 51, 61, 16'h104, 16'h023D, 16'h023C));
    tbl.push_back(mk(P, 1, 3, 90, 70, 16'h105, 16'h035A, 16'h035A));
    tbl.push_back(mk(HE, 1, 8'h33, 8'h44, 0, 16'h106, 16'h3344, 16'h3344));
    tbl.push_back(mk(P, 1, 4, 10, 20, 16'h107, 16'h040C, 16'h040A));
    tbl.push_back(mk(P, 1, 5, 13, 30, 16'h108, 16'h0519, 16'h0514));
    // rounding at the top of the range
    tbl.push_back(mk(P, 1, 6, 255, 0, 16'h109, 16'h06FF, 16'h06FF));
    tbl.push_back(mk(P, 1, 7, 254, 255, 16'h10A, 16'h0780, 16'h0700));
    // frame start cuts a row short
    tbl.push_back(mk(P, 1, 8, 1, 2, 16'h10B, 16'h0801, 16'h0801));
    tbl.push_back(mk(FS, 1, 8'h77, 8'h88, 0, 16'h10C, 16'h7788, 16'h7788));
    tbl.push_back(mk(P, 1, 9, 3, 4, 16'h10D, 16'h0904, 16'h0903));
    tbl.push_back(mk(P, 1, 10, 5, 6, 16'h10E, 16'h0A05, 16'h0A04));
    tbl.push_back(mk(HE, 1, 8'h99, 8'hAA, 0, 16'h10F, 16'h99AA, 16'h99AA));
    // bypass frame, enable toggled mid-frame
    tbl.push_back(mk(FS, 0, 8'hBB, 8'hCC, 0, 16'h110, 16'hBBCC, 16'hBBCC));
    tbl.push_back(mk(P, 1, 5, 7, 9, 16'h111, 16'h0507, 16'h0507));
    tbl.push_back(mk(P, 0, 6, 8, 10, 16'h112, 16'h0608, 16'h0608));
    tbl.push_back(mk(HE, 1, 1, 2, 0, 16'h113, 16'h0102, 16'h0102));
    tbl.push_back(mk(P, 1, 11, 12, 13, 16'h114, 16'h0B0C, 16'h0B0C));
    tbl.push_back(mk(FS, 1, 3, 4, 0, 16'h115, 16'h0304, 16'h0304));
    tbl.push_back(mk(P, 0, 1, 2, 3, 16'h116, 16'h0104, 16'h0102));
    tbl.push_back(mk(P, 0, 4, 6, 7, 16'h117, 16'h0405, 16'h0403));
    tbl.push_back(mk(HE, 0, 0, 1, 0, 16'h118, 16'h0001, 16'h0001));

    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].dtype, tbl[i].en, tbl[i].y, tbl[i].u, tbl[i].v,
           tbl[i].meta, sel(tbl[i].e_avg, tbl[i].e_dec), 1, 1'b1);
    end

    // gapped pair: even waits 5 idle cycles for its partner
    send(P, 1, 30, 40, 50, 16'h200, sel(16'h1E29, 16'h1E28), 6, 1'b1);
    idle(5);
    send(P, 1, 31, 42, 52, 16'h201, sel(16'h1F33, 16'h1F32), 1, 1'b1);
    send(HE, 1, 8'h12, 8'h34, 0, 16'h202, 16'h1234, 1, 1'b1);
    idle(3);

    // reset with an even pixel held: it must vanish
    send(P, 1, 60, 61, 62, 16'h250, 16'h0, 0, 1'b0);
    #2 resetb = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk) resetb = 1'b1;
    @(posedge clk); #1;
    send(FS, 1, 8'hDE, 8'hAD, 0, 16'h300, 16'hDEAD, 1, 1'b1);
    send(P, 1, 70, 80, 90, 16'h301, sel(16'h4651, 16'h4650), 1, 1'b1);
    send(P, 1, 71, 82, 91, 16'h302, sel(16'h475B, 16'h475A), 1, 1'b1);
    send(HE, 1, 0, 0, 0, 16'h303, 16'h0000, 1, 1'b1);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) idle(1);
    idle(3);
    chk("drain_pending", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
